// File: rtl/tx_arb_pkg.sv
// Shared types and defaults for the TRN transmit-port arbiter.
package tx_arb_pkg;

  localparam int DEF_NUM_REQ      = 4;
  localparam int DEF_OFFER_CYCLES = 4;
  localparam int DEF_MAX_BUSY     = 1024;
  localparam int IDX_W            = 3;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'b0001,
    ST_OFFER = 4'b0010,
    ST_BUSY  = 4'b0100,
    ST_GUARD = 4'b1000
  } state_t;

endpackage

// File: rtl/tx_arb_rr_pick.sv
// Combinational round-robin picker: first requesting index after the last-served one.
module tx_arb_rr_pick
  import tx_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last,
  output logic               valid,
  output logic [IDX_W-1:0]   idx
);

  localparam logic [NUM_REQ-1:0] ONE = {{(NUM_REQ-1){1'b0}}, 1'b1};
  localparam logic [IDX_W:0]     NUM = (IDX_W+1)'(NUM_REQ);

  logic [IDX_W-1:0]   cand [NUM_REQ];
  logic [NUM_REQ-1:0] hit;

  // Candidate gi is the index gi+1 positions after last, modulo NUM_REQ.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cand
    logic [IDX_W:0] sum;
    assign sum      = {1'b0, last} + (IDX_W+1)'(gi + 1);
    assign cand[gi] = (sum >= NUM) ? IDX_W'(sum - NUM) : sum[IDX_W-1:0];
    assign hit[gi]  = |(req & (ONE << cand[gi]));
  end

  always_comb begin
    valid = |hit;
    idx   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (hit[k]) idx = cand[k];
    end
  end

endmodule

// File: rtl/tx_trn_arbiter.sv
// Round-robin arbiter handing the shared TRN transmit port to one of NUM_REQ requesters.
// Define TX_ARB_WATCHDOG_EN to build in the BUSY-tenure watchdog (wd_err).
module tx_trn_arbiter
  import tx_arb_pkg::*;
#(
  parameter int NUM_REQ      = DEF_NUM_REQ,
  parameter int OFFER_CYCLES = DEF_OFFER_CYCLES,
  parameter int MAX_BUSY     = DEF_MAX_BUSY
) (
  input  logic               trn_clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] driving_interface,
  output logic [NUM_REQ-1:0] my_turn,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               arb_busy,
  output logic               proto_err,
  output logic               wd_err
);

  localparam int                 OFF_W    = $clog2(OFFER_CYCLES + 1);
  localparam logic [OFF_W-1:0]   OFF_LAST = OFF_W'(OFFER_CYCLES - 1);
  localparam logic [OFF_W-1:0]   OFF_SAT  = OFF_W'(OFFER_CYCLES);
  localparam logic [NUM_REQ-1:0] ONE      = {{(NUM_REQ-1){1'b0}}, 1'b1};
  localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(NUM_REQ - 1);

  if (NUM_REQ < 2 || NUM_REQ > 8 || OFFER_CYCLES < 1 || MAX_BUSY < 1) begin : g_param_check
    $error("tx_trn_arbiter: parameter out of range");
  end

  state_t             state_reg, state_next;
  logic [NUM_REQ-1:0] my_turn_reg, my_turn_next;
  logic [IDX_W-1:0]   grant_idx_reg, grant_idx_next;
  logic [IDX_W-1:0]   last_reg, last_next;
  logic               arb_busy_reg, arb_busy_next;
  logic               proto_err_reg, proto_err_next;
  logic [OFF_W-1:0]   offer_cnt_reg, offer_cnt_next;

  logic [NUM_REQ-1:0] grant_oh;
  logic               di_own, di_other, di_multi;
  logic               pick_valid;
  logic [IDX_W-1:0]   pick_idx;
  logic               wd_expire;
  logic               wd_guard;

  assign grant_oh = ONE << grant_idx_reg;
  assign di_own   = |(driving_interface & grant_oh);
  assign di_other = |(driving_interface & ~grant_oh);
  assign di_multi = |(driving_interface & (driving_interface - ONE));

  tx_arb_rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_pick (
    .req   (req),
    .last  (last_reg),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

`ifdef TX_ARB_WATCHDOG_EN
  localparam int               BUSY_W    = $clog2(MAX_BUSY + 1);
  localparam logic [BUSY_W-1:0] BUSY_LAST = BUSY_W'(MAX_BUSY - 1);
  localparam logic [BUSY_W-1:0] BUSY_SAT  = BUSY_W'(MAX_BUSY);

  logic [BUSY_W-1:0] busy_cnt_reg;
  logic              wd_err_reg;
  logic              wd_guard_reg;

  assign wd_expire = (busy_cnt_reg >= BUSY_LAST);
  assign wd_guard  = wd_guard_reg;
  assign wd_err    = wd_err_reg;

  // wd_guard_reg keeps the expired owner from re-entering BUSY as a late accept.
  always_ff @(posedge trn_clk) begin
    if (reset) begin
      busy_cnt_reg <= '0;
      wd_err_reg   <= 1'b0;
      wd_guard_reg <= 1'b0;
    end else begin
      wd_guard_reg <= 1'b0;
      if (state_reg == ST_BUSY && di_own) begin
        if (wd_expire) begin
          wd_err_reg   <= 1'b1;
          wd_guard_reg <= 1'b1;
          busy_cnt_reg <= '0;
        end else if (busy_cnt_reg != BUSY_SAT) begin
          busy_cnt_reg <= busy_cnt_reg + BUSY_W'(1);
        end
      end else begin
        busy_cnt_reg <= '0;
      end
    end
  end
`else
  assign wd_expire = 1'b0;
  assign wd_guard  = 1'b0;
  assign wd_err    = 1'b0;
`endif

  always_comb begin
    state_next     = state_reg;
    my_turn_next   = my_turn_reg;
    grant_idx_next = grant_idx_reg;
    last_next      = last_reg;
    arb_busy_next  = arb_busy_reg;
    offer_cnt_next = offer_cnt_reg;
    proto_err_next = proto_err_reg | di_other | di_multi;

    case (state_reg)
      ST_IDLE: begin
        my_turn_next   = '0;
        offer_cnt_next = '0;
        if (pick_valid) begin
          grant_idx_next = pick_idx;
          my_turn_next   = ONE << pick_idx;
          state_next     = ST_OFFER;
        end
      end
      ST_OFFER: begin
        if (di_own) begin
          my_turn_next  = '0;
          arb_busy_next = 1'b1;
          state_next    = ST_BUSY;
        end else if (offer_cnt_reg >= OFF_LAST) begin
          my_turn_next = '0;
          last_next    = grant_idx_reg;
          state_next   = ST_GUARD;
        end else if (offer_cnt_reg != OFF_SAT) begin
          offer_cnt_next = offer_cnt_reg + OFF_W'(1);
        end
      end
      ST_GUARD: begin
        my_turn_next   = '0;
        offer_cnt_next = '0;
        if (di_own && !wd_guard) begin
          arb_busy_next = 1'b1;
          state_next    = ST_BUSY;
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_BUSY: begin
        my_turn_next   = '0;
        offer_cnt_next = '0;
        if (!di_own) begin
          arb_busy_next = 1'b0;
          last_next     = grant_idx_reg;
          state_next    = ST_IDLE;
        end else if (wd_expire) begin
          arb_busy_next = 1'b0;
          last_next     = grant_idx_reg;
          state_next    = ST_GUARD;
        end
      end
      default: begin
        my_turn_next   = '0;
        arb_busy_next  = 1'b0;
        offer_cnt_next = '0;
        state_next     = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge trn_clk) begin
    if (reset) begin
      state_reg     <= ST_IDLE;
      my_turn_reg   <= '0;
      grant_idx_reg <= LAST_IDX;
      last_reg      <= LAST_IDX;
      arb_busy_reg  <= 1'b0;
      proto_err_reg <= 1'b0;
      offer_cnt_reg <= '0;
    end else begin
      state_reg     <= state_next;
      my_turn_reg   <= my_turn_next;
      grant_idx_reg <= grant_idx_next;
      last_reg      <= last_next;
      arb_busy_reg  <= arb_busy_next;
      proto_err_reg <= proto_err_next;
      offer_cnt_reg <= offer_cnt_next;
    end
  end

  assign my_turn   = my_turn_reg;
  assign grant_idx = grant_idx_reg;
  assign arb_busy  = arb_busy_reg;
  assign proto_err = proto_err_reg;

endmodule

// File: tb/tb_tx_trn_arbiter.sv
// Directed bench for tx_trn_arbiter: vector table plus hand-written multi-cycle sequences.
module tb_tx_trn_arbiter;

  logic       trn_clk;
  logic       reset;
  logic [3:0] req;
  logic [3:0] driving_interface;
  logic [3:0] my_turn;
  logic [2:0] grant_idx;
  logic       arb_busy;
  logic       proto_err;
  logic       wd_err;

  int total;
  int bad;

  tx_trn_arbiter #(
    .NUM_REQ      (4),
    .OFFER_CYCLES (4),
    .MAX_BUSY     (16)
  ) dut (
    .trn_clk           (trn_clk),
    .reset             (reset),
    .req               (req),
    .driving_interface (driving_interface),
    .my_turn           (my_turn),
    .grant_idx         (grant_idx),
    .arb_busy          (arb_busy),
    .proto_err         (proto_err),
    .wd_err            (wd_err)
  );

  initial trn_clk = 1'b0;
  always #5 trn_clk = ~trn_clk;

  typedef struct {
    logic [3:0] req;
    logic [3:0] di;
    logic [3:0] mt;
    logic [2:0] gi;
    logic       busy;
  } vec_t;

  vec_t vecs[18];

  task automatic tick();
    @(posedge trn_clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req = 4'b0000;
    driving_interface = 4'b0000;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [6:0] pat;
    int         exp_seq[4];
    int         waited;
    int         run_len;
    bit         done;
    int         exp_run;
    logic       exp_wd;

    total = 0;
    bad = 0;
    reset = 1'b0;
    req = 4'b0000;
    driving_interface = 4'b0000;

    // req, di, expected my_turn, grant_idx, arb_busy after the edge
    vecs[0]  = '{4'b0001, 4'b0000, 4'b0001, 3'd0, 1'b0};
    vecs[1]  = '{4'b0001, 4'b0001, 4'b0000, 3'd0, 1'b1};
    vecs[2]  = '{4'b0000, 4'b0001, 4'b0000, 3'd0, 1'b1};
    vecs[3]  = '{4'b0000, 4'b0000, 4'b0000, 3'd0, 1'b0};
    vecs[4]  = '{4'b0110, 4'b0000, 4'b0010, 3'd1, 1'b0};
    vecs[5]  = '{4'b0110, 4'b0000, 4'b0010, 3'd1, 1'b0};
    vecs[6]  = '{4'b0100, 4'b0010, 4'b0000, 3'd1, 1'b1};
    vecs[7]  = '{4'b0100, 4'b0000, 4'b0000, 3'd1, 1'b0};
    vecs[8]  = '{4'b0100, 4'b0000, 4'b0100, 3'd2, 1'b0};
    vecs[9]  = '{4'b0100, 4'b0100, 4'b0000, 3'd2, 1'b1};
    vecs[10] = '{4'b1001, 4'b0000, 4'b0000, 3'd2, 1'b0};
    vecs[11] = '{4'b1001, 4'b0000, 4'b1000, 3'd3, 1'b0};
    vecs[12] = '{4'b1001, 4'b1000, 4'b0000, 3'd3, 1'b1};
    vecs[13] = '{4'b1001, 4'b0000, 4'b0000, 3'd3, 1'b0};
    vecs[14] = '{4'b1001, 4'b0000, 4'b0001, 3'd0, 1'b0};
    vecs[15] = '{4'b0000, 4'b0001, 4'b0000, 3'd0, 1'b1};
    vecs[16] = '{4'b0000, 4'b0000, 4'b0000, 3'd0, 1'b0};
    vecs[17] = '{4'b0000, 4'b0000, 4'b0000, 3'd0, 1'b0};

    do_reset();
    check("reset_my_turn", my_turn, 4'b0000);
    check("reset_grant_idx", grant_idx, 3'd3);
    check("reset_arb_busy", arb_busy, 1'b0);
    check("reset_proto_err", proto_err, 1'b0);
    check("reset_wd_err", wd_err, 1'b0);

    for (int v = 0; v < 18; v++) begin
      req = vecs[v].req;
      driving_interface = vecs[v].di;
      tick();
      $display("vec %0d req=%b di=%b -> my_turn=%b grant=%0d busy=%b",
               v, vecs[v].req, vecs[v].di, my_turn, grant_idx, arb_busy);
      check($sformatf("vec%0d_my_turn", v), my_turn, vecs[v].mt);
      check($sformatf("vec%0d_grant_idx", v), grant_idx, vecs[v].gi);
      check($sformatf("vec%0d_arb_busy", v), arb_busy, vecs[v].busy);
    end
    check("vec_proto_err", proto_err, 1'b0);

    // Round-robin between 0 and 2, each holding the port 3 cycles
    do_reset();
    req = 4'b0101;
    exp_seq = '{0, 2, 0, 2};
    for (int t = 0; t < 4; t++) begin
      waited = 0;
      while (my_turn == 4'b0000 && waited < 10) begin
        tick();
        waited++;
      end
      check("rr_offer_seen", (my_turn != 4'b0000), 1'b1);
      check("rr_grant_idx", grant_idx, exp_seq[t]);
      check("rr_my_turn", my_turn, 4'b0001 << exp_seq[t]);
      $display("tenure %0d grant=%0d waited=%0d", t, grant_idx, waited);
      driving_interface = 4'b0001 << exp_seq[t];
      for (int c = 0; c < 3; c++) begin
        tick();
        check("rr_busy_no_turn", my_turn, 4'b0000);
        check("rr_busy", arb_busy, 1'b1);
      end
      driving_interface = 4'b0000;
      tick();
      check("rr_release_busy", arb_busy, 1'b0);
      check("rr_release_gap", my_turn, 4'b0000);
    end

    // Requester 1 never accepts: 4 offer cycles, GUARD, IDLE, re-offer
    do_reset();
    req = 4'b0010;
    pat = 7'b1001111;
    for (int k = 0; k < 7; k++) begin
      tick();
      $display("timeout step %0d my_turn=%b grant=%0d", k, my_turn, grant_idx);
      check("timeout_my_turn", my_turn, pat[k] ? 4'b0010 : 4'b0000);
    end
    check("timeout_grant_idx", grant_idx, 3'd1);

    // req dropping mid-offer keeps the full offer, then IDLE stays quiet
    do_reset();
    req = 4'b0001;
    tick();
    req = 4'b0000;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("req_drop_offer_held", my_turn, 4'b0001);
    end
    tick();
    check("req_drop_offer_end", my_turn, 4'b0000);
    tick();
    tick();
    $display("req drop sequence my_turn=%b busy=%b", my_turn, arb_busy);
    check("idle_no_req", my_turn, 4'b0000);

    // Late accept during GUARD
    do_reset();
    req = 4'b0010;
    for (int k = 0; k < 4; k++) tick();
    tick();
    check("late_guard_turn", my_turn, 4'b0000);
    check("late_guard_busy", arb_busy, 1'b0);
    driving_interface = 4'b0010;
    req = 4'b0000;
    tick();
    $display("late accept busy=%b proto_err=%b", arb_busy, proto_err);
    check("late_busy", arb_busy, 1'b1);
    check("late_no_turn", my_turn, 4'b0000);
    check("late_proto_err", proto_err, 1'b0);
    driving_interface = 4'b0000;
    tick();
    check("late_release", arb_busy, 1'b0);

    // Foreign requester driving while index 0 is offered
    do_reset();
    req = 4'b0001;
    tick();
    check("proto_grant0", grant_idx, 3'd0);
    req = 4'b0000;
    driving_interface = 4'b1000;
    tick();
    $display("protocol violation proto_err=%b my_turn=%b", proto_err, my_turn);
    check("proto_set", proto_err, 1'b1);
    check("proto_fsm_unaffected", my_turn, 4'b0001);
    driving_interface = 4'b0000;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("proto_sticky", proto_err, 1'b1);
    end
    do_reset();
    check("proto_cleared", proto_err, 1'b0);

    // Long tenure: 40 cycles of driving_interface
`ifdef TX_ARB_WATCHDOG_EN
    exp_run = 16;
    exp_wd = 1'b1;
`else
    exp_run = 40;
    exp_wd = 1'b0;
`endif
    do_reset();
    req = 4'b0001;
    tick();
    driving_interface = 4'b0001;
    run_len = 0;
    done = 1'b0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (!done && arb_busy) run_len++;
      else done = 1'b1;
    end
    $display("long tenure busy_run=%0d wd_err=%b", run_len, wd_err);
    check("long_busy_run", run_len, exp_run);
    check("long_wd_err", wd_err, exp_wd);
    driving_interface = 4'b0000;
    req = 4'b0000;
    tick();
    check("long_release", arb_busy, 1'b0);

    // Reset in the middle of a tenure
    do_reset();
    req = 4'b0110;
    tick();
    check("mid_reset_grant1", grant_idx, 3'd1);
    driving_interface = 4'b0010;
    tick();
    check("mid_reset_busy", arb_busy, 1'b1);
    tick();
    reset = 1'b1;
    tick();
    check("mid_reset_turn", my_turn, 4'b0000);
    check("mid_reset_arb_busy", arb_busy, 1'b0);
    check("mid_reset_grant_idx", grant_idx, 3'd3);
    reset = 1'b0;
    driving_interface = 4'b0000;
    req = 4'b0011;
    tick();
    $display("post reset grant=%0d my_turn=%b", grant_idx, my_turn);
    check("post_reset_grant", grant_idx, 3'd0);
    check("post_reset_turn", my_turn, 4'b0001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
